// File: rtl/adder_pipe_pkg.sv
// Shared definitions for the pipelined add/sub datapath:
// op codes and the op field width.
package adder_pipe_pkg;

   localparam int ADD_OP_W = 2;

   typedef enum logic [ADD_OP_W-1:0] {
      ADD_OP_ADD = 2'd0,
      ADD_OP_SUB = 2'd1,
      ADD_OP_ADC = 2'd2,
      ADD_OP_SBC = 2'd3
   } add_op_e;

endpackage

// File: rtl/adder_slice.sv
// One SW-bit carry slice: sum, carry out, and the carry
// into the slice MSB (used for the signed-overflow flag).
module adder_slice #(
   parameter int SW = 8
) (
   input  logic [SW-1:0] a,
   input  logic [SW-1:0] b,
   input  logic          ci,
   output logic [SW-1:0] s,
   output logic          co,
   output logic          c_msb
);

   if (SW == 1) begin : g_bit
      assign c_msb = ci;
      assign s     = a ^ b ^ ci;
   end else begin : g_vec
      logic [SW-1:0] lo;
      assign lo    = {1'b0, a[SW-2:0]} + {1'b0, b[SW-2:0]}
                   + {{(SW-1){1'b0}}, ci};
      assign c_msb = lo[SW-1];
      assign s     = {a[SW-1] ^ b[SW-1] ^ c_msb, lo[SW-2:0]};
   end

   assign co = (a[SW-1] & b[SW-1])
             | (c_msb & (a[SW-1] ^ b[SW-1]));

endmodule

// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit add/sub with carry-in ops and NZCV flags;
// one SW-bit carry slice per stage, valid/ready with global stall.
module adder_pipe
   import adder_pipe_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WIDTH-1:0]    A,
   input  logic [WIDTH-1:0]    B,
   input  logic [ADD_OP_W-1:0] op,
   input  logic                cin,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WIDTH-1:0]    SUM,
   output logic                CARRY_OUT,
   output logic                OVERFLOW,
   output logic                NEG,
   output logic                ZERO
);

   localparam int SW = WIDTH / STAGES;
   localparam int L  = STAGES - 1;

   logic              en;
   logic [STAGES-1:0] vld_q;
   logic [WIDTH-1:0]  b_in;
   logic              c0;

   always_comb begin
      b_in = B;
      c0   = 1'b0;
      case (op)
         ADD_OP_SUB: begin
            b_in = ~B;
            c0   = 1'b1;
         end
         ADD_OP_ADC: c0 = cin;
         ADD_OP_SBC: begin
            b_in = ~B;
            c0   = cin;
         end
         default: ;
      endcase
   end

   assign en        = out_ready | ~vld_q[L];
   assign in_ready  = en;
   assign out_valid = vld_q[L];

   always_ff @(posedge clk) begin
      if (rst)
         vld_q <= '0;
      else if (en)
         vld_q <= (vld_q << 1) | STAGES'(in_valid);
   end

   // Each stage keeps only the operand bits still to be added
   // and the sum bits already produced.
   for (genvar k = 0; k < STAGES; k++) begin : stg
      localparam int RW = WIDTH - k * SW;
      localparam int DW = (k + 1) * SW;

      logic [RW-1:0] a_rem;
      logic [RW-1:0] b_rem;
      logic [DW-1:0] sum_d;
      logic [DW-1:0] sum_q;
      logic [SW-1:0] s;
      logic          ci;
      logic          co;
      logic          cm;
      logic          co_q;

      if (k == 0) begin : g_in
         assign a_rem = A;
         assign b_rem = b_in;
         assign ci    = c0;
         assign sum_d = s;
      end else begin : g_in
         assign a_rem = stg[k-1].g_ops.a_q;
         assign b_rem = stg[k-1].g_ops.b_q;
         assign ci    = stg[k-1].co_q;
         assign sum_d = {s, stg[k-1].sum_q};
      end

      adder_slice #(.SW(SW)) u_slice (
         .a     (a_rem[SW-1:0]),
         .b     (b_rem[SW-1:0]),
         .ci    (ci),
         .s     (s),
         .co    (co),
         .c_msb (cm)
      );

      always_ff @(posedge clk) begin
         if (en) begin
            co_q  <= co;
            sum_q <= sum_d;
         end
      end

      if (k < L) begin : g_ops
         logic [RW-SW-1:0] a_q;
         logic [RW-SW-1:0] b_q;
         always_ff @(posedge clk) begin
            if (en) begin
               a_q <= a_rem[RW-1:SW];
               b_q <= b_rem[RW-1:SW];
            end
         end
      end

      if (k == L) begin : g_last
         logic v_q;
         always_ff @(posedge clk) begin
            if (en)
               v_q <= co ^ cm;
         end
      end else begin : g_mid
         logic unused_cm;
         assign unused_cm = cm;
      end
   end

   // Data registers carry no reset; outputs are gated by valid.
   assign SUM       = out_valid ? stg[L].sum_q : '0;
   assign CARRY_OUT = out_valid & stg[L].co_q;
   assign OVERFLOW  = out_valid & stg[L].g_last.v_q;
   assign NEG       = SUM[WIDTH-1];
   assign ZERO      = out_valid & (SUM == '0);

endmodule

// File: tb/tb_adder_pipe.sv
// Randomised scoreboard bench for adder_pipe at three
// parameterisations: (32,4), (64,8) and (32,1).
module tb_adder_pipe;
   import adder_pipe_pkg::*;

   typedef struct packed {
      logic [63:0] sum;
      logic        c;
      logic        v;
      logic        n;
      logic        z;
   } res_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        out_ready;
   logic        cin;
   logic [63:0] a64;
   logic [63:0] b64;
   logic [1:0]  op;

   logic        r0_in_ready, r0_out_valid, r0_c, r0_v, r0_n, r0_z;
   logic [31:0] r0_sum;
   logic        r1_in_ready, r1_out_valid, r1_c, r1_v, r1_n, r1_z;
   logic [63:0] r1_sum;
   logic        r2_in_ready, r2_out_valid, r2_c, r2_v, r2_n, r2_z;
   logic [31:0] r2_sum;

   int   n_tests = 0;
   int   n_fail  = 0;
   bit   rand_rdy = 1'b0;
   res_t sbq[3][$];
   int   wid[3] = '{32, 64, 32};

   bit          hold = 1'b0;
   logic [31:0] p_sum;
   logic [3:0]  p_flags;

   always #5 clk = ~clk;

   adder_pipe #(.WIDTH(32), .STAGES(4)) u_dut0 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(r0_in_ready),
      .A(a64[31:0]), .B(b64[31:0]), .op(op), .cin(cin),
      .out_valid(r0_out_valid), .out_ready(out_ready),
      .SUM(r0_sum), .CARRY_OUT(r0_c), .OVERFLOW(r0_v),
      .NEG(r0_n), .ZERO(r0_z)
   );

   adder_pipe #(.WIDTH(64), .STAGES(8)) u_dut1 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(r1_in_ready),
      .A(a64), .B(b64), .op(op), .cin(cin),
      .out_valid(r1_out_valid), .out_ready(1'b1),
      .SUM(r1_sum), .CARRY_OUT(r1_c), .OVERFLOW(r1_v),
      .NEG(r1_n), .ZERO(r1_z)
   );

   adder_pipe #(.WIDTH(32), .STAGES(1)) u_dut2 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(r2_in_ready),
      .A(a64[31:0]), .B(b64[31:0]), .op(op), .cin(cin),
      .out_valid(r2_out_valid), .out_ready(1'b1),
      .SUM(r2_sum), .CARRY_OUT(r2_c), .OVERFLOW(r2_v),
      .NEG(r2_n), .ZERO(r2_z)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference: plain wide arithmetic, V from operand/result signs.
   function automatic res_t model(input int w, input logic [63:0] a,
                                  input logic [63:0] b,
                                  input logic [1:0] o, input logic ci);
      logic [63:0] mask, aa, bb, s;
      logic [64:0] full;
      logic        c0;
      res_t        r;
      mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      aa   = a & mask;
      bb   = (o == ADD_OP_SUB || o == ADD_OP_SBC) ? (~b & mask) : (b & mask);
      c0   = (o == ADD_OP_SUB) ? 1'b1 :
             (o == ADD_OP_ADC || o == ADD_OP_SBC) ? ci : 1'b0;
      full = {1'b0, aa} + {1'b0, bb} + {64'd0, c0};
      s    = full[63:0] & mask;
      r.sum = s;
      r.c   = full[w];
      r.v   = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
      r.n   = s[w-1];
      r.z   = (s == 64'd0);
      return r;
   endfunction

   task automatic score(input int id, input logic vi, input logic ri,
                        input logic vo, input logic ro,
                        input logic [63:0] sum, input logic c,
                        input logic v, input logic n, input logic z);
      res_t e;
      if (rst) begin
         sbq[id].delete();
         return;
      end
      if (vo && ro) begin
         if (sbq[id].size() == 0)
            chk($sformatf("spurious%0d", id), 64'd1, 64'd0);
         else begin
            e = sbq[id].pop_front();
            chk($sformatf("sum%0d", id), sum, e.sum);
            chk($sformatf("nzcv%0d", id), {60'd0, n, z, c, v},
                {60'd0, e.n, e.z, e.c, e.v});
         end
      end
      if (vi && ri)
         sbq[id].push_back(model(wid[id], a64, b64, op, cin));
   endtask

   always @(negedge clk) begin
      score(0, in_valid, r0_in_ready, r0_out_valid, out_ready,
            64'(r0_sum), r0_c, r0_v, r0_n, r0_z);
      score(1, in_valid, r1_in_ready, r1_out_valid, 1'b1,
            r1_sum, r1_c, r1_v, r1_n, r1_z);
      score(2, in_valid, r2_in_ready, r2_out_valid, 1'b1,
            64'(r2_sum), r2_c, r2_v, r2_n, r2_z);
      if (!rst)
         chk("in_ready", 64'(r0_in_ready),
             64'(!(r0_out_valid && !out_ready)));
      if (hold) begin
         chk("hold_sum", 64'(r0_sum), 64'(p_sum));
         chk("hold_flags", 64'({r0_n, r0_z, r0_c, r0_v}), 64'(p_flags));
      end
      hold    = r0_out_valid && !out_ready && !rst;
      p_sum   = r0_sum;
      p_flags = {r0_n, r0_z, r0_c, r0_v};
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_rdy)
            out_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic send(input logic [63:0] a, input logic [63:0] b,
                       input logic [1:0] o, input logic ci);
      bit ok = 1'b0;
      a64 = a;
      b64 = b;
      op  = o;
      cin = ci;
      in_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (r0_in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok)
         chk("send_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      op = 2'bxx;
   endtask

   task automatic drain();
      bit done = 1'b0;
      rand_rdy  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (sbq[0].size() == 0 && sbq[1].size() == 0 &&
             sbq[2].size() == 0 && !r0_out_valid &&
             !r1_out_valid && !r2_out_valid) begin
            done = 1'b1;
            break;
         end
      end
      chk("drain", 64'(done), 64'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic lat_test(input string tag);
      int l[3];
      l = '{-1, -1, -1};
      send(64'd5, 64'd7, ADD_OP_ADD, 1'b0);
      for (int n = 0; n < 12; n++) begin
         if (r0_out_valid && l[0] < 0) l[0] = n;
         if (r1_out_valid && l[1] < 0) l[1] = n;
         if (r2_out_valid && l[2] < 0) l[2] = n;
         @(posedge clk);
         #1;
      end
      chk({tag, "_s4"}, 64'(l[0]), 64'd3);
      chk({tag, "_s8"}, 64'(l[1]), 64'd7);
      chk({tag, "_s1"}, 64'(l[2]), 64'd0);
   endtask

   function automatic logic [63:0] pick();
      case ($urandom_range(0, 4))
         0: return 64'hFFFF_FFFF_FFFF_FFFF;
         1: return 64'h7FFF_FFFF_7FFF_FFFF;
         2: return 64'($urandom_range(0, 3));
         3: return {32'h0, $urandom};
         default: return {$urandom, $urandom};
      endcase
   endfunction

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      cin = 1'b0;
      a64 = '0;
      b64 = '0;
      op = 2'b00;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_valid", 64'(r0_out_valid), 64'd0);
      chk("rst_sum", 64'(r0_sum), 64'd0);
      chk("rst_flags", 64'({r0_n, r0_z, r0_c, r0_v}), 64'd0);
      chk("rst_ready", 64'(r0_in_ready), 64'd1);
      @(posedge clk);
      #1;

      lat_test("lat");
      drain();

      send(64'h1, 64'h2, ADD_OP_ADD, 1'b0);
      send(64'hFFFF_FFFF, 64'h1, ADD_OP_ADD, 1'b0);
      send(64'h7FFF_FFFF, 64'h1, ADD_OP_ADD, 1'b1);
      send(64'h0, 64'h1, ADD_OP_SUB, 1'b0);
      send(64'h3, 64'h1, ADD_OP_SBC, 1'b0);
      send(64'hFFFF_FFFF, 64'h0, ADD_OP_ADC, 1'b1);
      send(64'h0000_FFFF, 64'h1, ADD_OP_ADD, 1'b0);
      send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, ADD_OP_ADD, 1'b0);
      send(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, ADD_OP_ADD, 1'b0);
      send(64'h8000_0000_0000_0000, 64'h1, ADD_OP_SUB, 1'b1);
      drain();

      rand_rdy = 1'b1;
      for (int i = 0; i < 60; i++) begin
         send(pick(), pick(), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)));
         if ($urandom_range(0, 5) == 0) begin
            @(posedge clk);
            #1;
         end
      end
      drain();

      send(64'h11, 64'h22, ADD_OP_ADD, 1'b0);
      send(64'h33, 64'h44, ADD_OP_SUB, 1'b0);
      send(64'h55, 64'h66, ADD_OP_ADC, 1'b1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_valid", 64'(r0_out_valid), 64'd0);
      chk("mid_rst_sum", 64'(r0_sum), 64'd0);
      chk("mid_rst_valid8", 64'(r1_out_valid), 64'd0);
      repeat (12) @(posedge clk);
      #1;
      lat_test("rlat");
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/adder_pipe.md
Name: adder_pipe

Overview:
- Parametrised, pipelined successor to the combinational adder32 add/sub datapath.
- Splits a WIDTH-bit carry chain into STAGES equal slices, one slice per pipeline stage. This lets wide adds close timing at the CPU clock.
- Adds carry-in ops (ADC/SBC) and a full NZCV flag set.
- Valid/ready handshake on input and output.
- Sits between the issue stage and ALU writeback; the ALU result mux consumes SUM and the flags.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages and carry slices (1..WIDTH); slice width SW = WIDTH/STAGES.

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts a beat this cycle
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- op  in  2  `ADD_OP_ADD=0, `ADD_OP_SUB=1, `ADD_OP_ADC=2, `ADD_OP_SBC=3
- cin  in  1  carry-in; used by ADC/SBC only
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accepts the result
- SUM  out  WIDTH  result
- CARRY_OUT  out  1  C flag; for SUB/SBC, 1 = no borrow
- OVERFLOW  out  1  V flag (signed overflow)
- NEG  out  1  N flag = SUM[WIDTH-1]
- ZERO  out  1  Z flag = (SUM == 0)

Behaviour:
- Arithmetic: SUM = A + B' + c0, all mod 2^WIDTH.
  - ADD: B' = B, c0 = 0
  - SUB: B' = ~B, c0 = 1
  - ADC: B' = B, c0 = cin
  - SBC: B' = ~B, c0 = cin
- CARRY_OUT is the carry out of bit WIDTH-1.
- OVERFLOW is the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
- Pipeline structure:
  - Stage k (0..STAGES-1) adds slice bits [k*SW +: SW] of A and B' plus the carry registered from stage k-1 (c0 for k=0).
  - Unprocessed upper operand slices and completed lower SUM slices travel with the beat in stage registers.
  - Operand inversion and c0 selection happen at the stage-0 input and are registered with the beat.
- Latency: a beat accepted at edge t presents out_valid=1 after edge t+STAGES-1, i.e. the output register is the stage STAGES-1 register. STAGES=1 means single-cycle registered.
- Throughput: one beat per cycle when out_ready=1.
- Stall: global enable en = out_ready | ~out_valid, and in_ready = en.
  - When en=0, every stage register, valid bit and output holds unchanged.
  - A beat transfers only when in_valid & in_ready.
  - Each stage carries its own valid bit; bubbles propagate as valid=0.
- Output stability: while out_valid=1 and out_ready=0, SUM and all flags are held stable.
- ZERO and NEG are computed from the fully assembled SUM in the final stage, combinationally off the output register.
- Reset (sync, rst=1 at an edge):
  - All stage valid bits and out_valid clear; SUM=0 and all flags 0.
  - In-flight beats are dropped.
  - in_ready is 1 in the cycle after reset.
- rst overrides en.
- Stage data registers need no reset; outputs are gated or registered to 0.
- Simultaneous events: input accept and output drain in the same cycle is legal; the pipeline shifts by one.
- Boundaries:
  - WIDTH-bit wrap-around is silent; only C/V report it.
  - The cin port is ignored for ADD/SUB.
  - An X on op while in_valid=0 must not affect the outputs.

Decomposition:
- alu_defs.vh gains the op codes `ADD_OP_ADD/SUB/ADC/SBC and a `ADD_OP_W=2 width define.
- One sub-module, adder_slice #(SW): combinational, inputs a, b, ci; outputs s, co, c_msb (carry into the slice MSB).
- Stage k instantiates adder_slice; the top level only uses c_msb of the last slice, for OVERFLOW.
- Pipeline registers and the handshake stay in adder_pipe.

Test Plan:
- Default params, ADD A=0x00000001, B=0x00000002 -> after 4 cycles SUM=0x00000003, C=0, V=0, N=0, Z=0.
- ADD A=0xFFFFFFFF, B=0x00000001 -> SUM=0x00000000, C=1, V=0, Z=1. ADD A=0x7FFFFFFF, B=1 -> SUM=0x80000000, C=0, V=1, N=1.
- SUB A=0, B=1 -> SUM=0xFFFFFFFF, C=0 (borrow), V=0. SBC A=3, B=1, cin=0 -> SUM=0x00000001, C=1. ADC A=0xFFFFFFFF, B=0, cin=1 -> SUM=0, C=1, Z=1.
- Carry across slice boundaries: ADD A=0x0000FFFF, B=1 -> 0x00010000. Repeat with STAGES=1, 2, 8 and WIDTH=64 (A=0xFFFFFFFFFFFFFFFF + 1 -> 0, C=1); results must be identical to a reference model.
- Backpressure: stream 8 back-to-back beats with out_ready toggling randomly -> no beat lost, duplicated or reordered; outputs stable while out_valid & ~out_ready; in_ready=0 exactly when out_valid & ~out_ready.
- Reset mid-stream: rst=1 for 1 cycle with 3 beats in flight -> next cycle out_valid=0 and SUM=0; no stale beat ever emerges; a new beat's latency is STAGES.
